// File: rtl/sample_packer_12to16.sv
// sample_packer_12to16: packs 12-bit ADC samples into 16-bit FIFO words (4 samples -> 3 words),
// or one zero-extended word per sample, with drop-on-full accounting.
module sample_packer_12to16 #(
  parameter bit PACK_12 = 1'b1
) (
  input  logic        clk_pixel,
  input  logic        rstn,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  input  logic        test_mode,
  input  logic        fifo_full,
  output logic [15:0] fifo_data,
  output logic        fifo_write_en,
  output logic [15:0] overflow_cnt
);
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;
  logic [1:0]  phase_q, phase_d;
  logic [11:0] hold_q, hold_d;
  logic [11:0] test_cnt_q, test_cnt_d;
  logic        mode_q, mode_d;
  logic [15:0] data_q, data_d;
  logic [15:0] ovf_q, ovf_d;
  logic        we_q, we_d;
  logic        start, produce, drop;
  logic [11:0] eff;
  logic [15:0] word;
  // The mode sampled at a group start also applies to that group's first sample.
  always_comb begin
    start      = !PACK_12 || phase_q == P0;
    mode_d     = (sample_valid && start) ? test_mode : mode_q;
    eff        = mode_d ? test_cnt_q : sample_in;
    test_cnt_d = sample_valid ? test_cnt_q + 12'd1 : test_cnt_q;
    produce    = sample_valid && (!PACK_12 || phase_q != P0);
    drop       = produce && fifo_full;
    we_d       = produce && !fifo_full;
    word       = !PACK_12       ? {4'h0, eff} :
                 phase_q == P1  ? {hold_q, eff[11:8]} :
                 phase_q == P2  ? {hold_q[7:0], eff[11:4]} :
                                  {hold_q[3:0], eff};
    hold_d     = (!sample_valid || !PACK_12) ? hold_q :
                 phase_q == P0  ? eff :
                 phase_q == P1  ? {4'h0, eff[7:0]} :
                 phase_q == P2  ? {8'h0, eff[3:0]} : 12'h000;
    data_d     = we_d ? word : data_q;
    ovf_d      = (drop && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
    phase_d    = !PACK_12 ? P0 : !sample_valid ? phase_q : drop ? P0 : phase_q + 2'd1;
  end
  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      phase_q    <= P0;
      hold_q     <= 12'h000;
      test_cnt_q <= 12'h000;
      mode_q     <= 1'b0;
      data_q     <= 16'h0000;
      ovf_q      <= 16'h0000;
      we_q       <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      test_cnt_q <= test_cnt_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      we_q       <= we_d;
    end
  end
  assign fifo_data     = data_q;
  assign fifo_write_en = we_q;
  assign overflow_cnt  = ovf_q;
endmodule
